// File: rtl/sram22_req_ctrl.sv
// Request-channel front end for the sram22 single-port macro: issues commands,
// captures one-cycle-latency read data into a response FIFO, and optionally zero-fills after reset.
`timescale 1ns/1ps
module sram22_req_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned WMASK_WIDTH    = 4,
    parameter int unsigned RSP_DEPTH      = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   init_done,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_addr_q;
    logic                    live_q;
    logic                    init_done_q;

    logic                    rd_pending_q, rd_pending_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0]   fifo_q [RSP_DEPTH];

    logic                    push, pop, fire_rd, credit_ok;
    logic [OCC_W-1:0]        occ_c;

    // Sweep/run control; live_q holds off the first clear write until one edge after reset release
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= RST_STATE;
            clr_addr_q  <= '0;
            live_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                ST_CLEAR: begin
                    if (live_q) begin
                        clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
                        if (clr_addr_q == '1) begin
                            state_q     <= ST_RUN;
                            init_done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: init_done_q <= 1'b1;
            endcase
        end
    end

    assign pop       = rsp_valid & rsp_ready;
    assign push      = rd_pending_q;
    // Credits count both stored entries and the read still in flight in the macro
    assign occ_c     = OCC_W'(cnt_q) + OCC_W'(rd_pending_q) - OCC_W'(pop);
    assign credit_ok = occ_c < OCC_W'(RSP_DEPTH);

    always_comb begin
        req_ready  = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = req_wmask;
        sram_addr  = req_addr;
        sram_din   = req_wdata;
        if (state_q == ST_CLEAR) begin
            sram_we    = live_q;
            sram_wmask = '1;
            sram_addr  = clr_addr_q;
            sram_din   = '0;
        end else begin
            req_ready = init_done_q & (req_we | credit_ok);
            sram_we   = req_valid & req_ready & req_we;
        end
    end

    assign fire_rd = (state_q == ST_RUN) & req_valid & req_ready & ~req_we;

    always_comb begin
        rd_pending_d = fire_rd;
        cnt_d        = cnt_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_pending_q <= 1'b0;
            cnt_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            rd_pending_q <= rd_pending_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sram_dout;
        end
    end

    assign rsp_valid = (cnt_q != '0);
    assign rsp_rdata = fifo_q[rd_ptr_q];
    assign init_done = init_done_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstb)
        push |-> (cnt_q != CNT_W'(RSP_DEPTH)));

endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Self-checking bench for sram22_req_ctrl with a behavioural sram22 macro and a read scoreboard.
`timescale 1ns/1ps
module tb_sram22_req_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned MW    = 4;
    localparam int unsigned DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rstb;
    logic          req_valid, req_ready, req_we;
    logic [MW-1:0] req_wmask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    logic [DW-1:0] macro_mem [DEPTH];
    logic [DW-1:0] ref_mem   [DEPTH];
    logic [DW-1:0] sb     [$];
    logic [DW-1:0] got_q  [$];
    int            gotc_q [$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    sram22_req_ctrl dut (
        .clk        (clk),
        .rstb       (rstb),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .init_done  (init_done),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    // Macro model: one-cycle read latency, dout undefined after a write cycle
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < MW; b++)
                if (sram_wmask[b]) macro_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            sram_dout <= 'x;
        end else begin
            sram_dout <= macro_mem[sram_addr];
        end
    end

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        sb.delete();
        got_q.delete();
        gotc_q.delete();
    endtask

    task automatic drive_cycle(input bit v, input bit we, input logic [MW-1:0] m,
                               input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input bit rr, output bit fired);
        @(negedge clk);
        cyc++;
        req_valid = v; req_we = we; req_wmask = m; req_addr = a; req_wdata = d; rsp_ready = rr;
        #1;
        fired = v && (req_ready === 1'b1);
        if (rr && (rsp_valid === 1'b1)) begin
            got_q.push_back(rsp_rdata);
            gotc_q.push_back(cyc);
        end
        if (fired && we) begin
            for (int b = 0; b < MW; b++)
                if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else if (fired) begin
            sb.push_back(ref_mem[a]);
        end
    endtask

    task automatic drain(input int max_cyc);
        bit f;
        for (int i = 0; i < max_cyc && got_q.size() < sb.size(); i++)
            drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, f);
        drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, f);
    endtask

    task automatic run_sweep(output int nwe, output int bad, output int first_addr, output bit done);
        nwe = 0; bad = 0; first_addr = -1; done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (sram_we === 1'b1) begin
                if (first_addr < 0) first_addr = int'(sram_addr);
                if (sram_addr !== AW'(nwe) || sram_din !== '0 || sram_wmask !== 4'hF) bad++;
                nwe++;
            end
            if (req_ready !== 1'b0) bad++;
        end
    endtask

    task automatic test_reset();
        int nwe, bad, fa;
        bit done, f;
        logic [DW-1:0] exp, got;
        rstb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_wmask = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
        checks++; if (sram_we !== 1'b0) begin failures++; $display("FAIL reset_sram_we got=%b exp=0", sram_we); end
        @(negedge clk);
        rstb = 1'b1;
        run_sweep(nwe, bad, fa, done);
        checks++; if (!done) begin failures++; $display("FAIL sweep_done timeout"); end
        checks++; if (nwe != 1024) begin failures++; $display("FAIL sweep_len got=%0d exp=1024", nwe); end
        checks++; if (fa != 0) begin failures++; $display("FAIL sweep_first_addr got=%0d exp=0", fa); end
        checks++; if (bad != 0) begin failures++; $display("FAIL sweep_cmd got=%0d bad cycles exp=0", bad); end
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_clear got=%b exp=1", req_ready); end
        clear_ref();
        drive_cycle(1'b1, 1'b0, '0, 10'h3FF, '0, 1'b1, f);
        drain(10);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL read_3ff_count got=%0d exp=1", got_q.size()); end
        while (sb.size() != 0 && got_q.size() != 0) begin
            exp = sb.pop_front(); got = got_q.pop_front();
            checks++; if (got !== 32'h0 || got !== exp) begin failures++; $display("FAIL read_3ff got=%h exp=%h", got, exp); end
        end
        clear_ref();
    endtask

    task automatic test_partial_write();
        bit f;
        logic [DW-1:0] got;
        drive_cycle(1'b1, 1'b1, 4'hF,    10'h005, 32'hDEADBEEF, 1'b1, f);
        drive_cycle(1'b1, 1'b1, 4'b0101, 10'h005, 32'h11223344, 1'b1, f);
        drive_cycle(1'b1, 1'b0, 4'h0,    10'h005, 32'h0,        1'b1, f);
        drain(10);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL partial_count got=%0d exp=1", got_q.size()); end
        while (sb.size() != 0 && got_q.size() != 0) begin
            void'(sb.pop_front());
            got = got_q.pop_front();
            checks++; if (got !== 32'hDE22BE44) begin failures++; $display("FAIL partial_write got=%h exp=de22be44", got); end
        end
        sb.delete(); got_q.delete(); gotc_q.delete();
    endtask

    task automatic test_back_to_back();
        bit f;
        int fires, fc0, k;
        logic [DW-1:0] exp, got;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, 4'hF, AW'(i), DW'(i) * 32'h01010101, 1'b1, f);
        fires = 0; fc0 = -1;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 1'b0, 4'h0, AW'(i), '0, 1'b1, f);
            if (f) begin
                fires++;
                if (fc0 < 0) fc0 = cyc;
            end
        end
        drain(12);
        checks++; if (fires != 8) begin failures++; $display("FAIL b2b_fires got=%0d exp=8", fires); end
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", got_q.size()); end
        k = 0;
        while (sb.size() != 0 && got_q.size() != 0) begin
            exp = sb.pop_front(); got = got_q.pop_front();
            checks++; if (got !== exp) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, got, exp); end
            checks++; if (gotc_q[k] != fc0 + 2 + k) begin failures++; $display("FAIL b2b_timing[%0d] got=%0d exp=%0d", k, gotc_q[k], fc0 + 2 + k); end
            k++;
        end
        sb.delete(); got_q.delete(); gotc_q.delete();
    endtask

    task automatic test_backpressure();
        bit f;
        int nacc;
        logic [DW-1:0] exp, got;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, 4'h0, AW'(i), '0, 1'b0, f);
            if (f) nacc++;
        end
        checks++; if (nacc != 2) begin failures++; $display("FAIL bp_reads_accepted got=%0d exp=2", nacc); end
        drive_cycle(1'b1, 1'b0, 4'h0, 10'h006, '0, 1'b0, f);
        checks++; if (f) begin failures++; $display("FAIL bp_read_ready got=1 exp=0"); end
        drive_cycle(1'b1, 1'b1, 4'hF, 10'h100, 32'h12345678, 1'b0, f);
        checks++; if (!f) begin failures++; $display("FAIL bp_write_ready got=0 exp=1"); end
        drain(10);
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", got_q.size()); end
        while (sb.size() != 0 && got_q.size() != 0) begin
            exp = sb.pop_front(); got = got_q.pop_front();
            checks++; if (got !== exp) begin failures++; $display("FAIL bp_data got=%h exp=%h", got, exp); end
        end
        sb.delete(); got_q.delete(); gotc_q.delete();
    endtask

    task automatic test_reset_mid_clear();
        int nwe, bad, fa;
        bit done, found;
        rstb = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rstb = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (sram_we === 1'b1 && sram_addr === 10'h200) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL midclr_reach_200 timeout"); end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, init_done, sram_we} !== 4'b0000) begin
            failures++;
            $display("FAIL midclr_reset_outputs got=%b exp=0000", {req_ready, rsp_valid, init_done, sram_we});
        end
        @(negedge clk);
        rstb = 1'b1;
        run_sweep(nwe, bad, fa, done);
        checks++; if (!done) begin failures++; $display("FAIL midclr_done timeout"); end
        checks++; if (nwe != 1024) begin failures++; $display("FAIL midclr_len got=%0d exp=1024", nwe); end
        checks++; if (fa != 0) begin failures++; $display("FAIL midclr_first_addr got=%0d exp=0", fa); end
        checks++; if (bad != 0) begin failures++; $display("FAIL midclr_cmd got=%0d bad cycles exp=0", bad); end
        clear_ref();
    endtask

    task automatic test_alternating();
        bit f;
        int nf, k;
        logic [DW-1:0] exp, got;
        logic [DW-1:0] lit [2];
        lit[0] = 32'hA5A5A5A5;
        lit[1] = 32'h5A5A5A5A;
        nf = 0;
        drive_cycle(1'b1, 1'b1, 4'hF, 10'h040, 32'hA5A5A5A5, 1'b1, f); nf += int'(f);
        drive_cycle(1'b1, 1'b0, 4'h0, 10'h040, '0,           1'b1, f); nf += int'(f);
        drive_cycle(1'b1, 1'b1, 4'hF, 10'h040, 32'h5A5A5A5A, 1'b1, f); nf += int'(f);
        drive_cycle(1'b1, 1'b0, 4'h0, 10'h040, '0,           1'b1, f); nf += int'(f);
        drain(10);
        checks++; if (nf != 4) begin failures++; $display("FAIL alt_fires got=%0d exp=4", nf); end
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL alt_count got=%0d exp=2", got_q.size()); end
        k = 0;
        while (sb.size() != 0 && got_q.size() != 0 && k < 2) begin
            exp = sb.pop_front(); got = got_q.pop_front();
            checks++; if (got !== lit[k] || got !== exp) begin failures++; $display("FAIL alt_data[%0d] got=%h exp=%h", k, got, lit[k]); end
            k++;
        end
        sb.delete(); got_q.delete(); gotc_q.delete();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) macro_mem[i] = $urandom();
        test_reset();
        test_partial_write();
        test_back_to_back();
        test_backpressure();
        test_alternating();
        test_reset_mid_clear();
        test_partial_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule

// File: doc/sram22_req_ctrl.md
Name: sram22_req_ctrl

Overview:
- Initiator-side controller for the sram22 single-port synchronous SRAM macro interface (we, wmask, addr, din in; dout out, one-cycle read latency).
- Converts a valid/ready request channel into macro commands, captures read data one cycle after issue, and returns it through a backpressured response FIFO.
- When CLEAR_ON_RESET=1, it zero-fills the whole array after reset before accepting requests, because the macro is not guaranteed to power up to zero.

Parameters:
DATA_WIDTH, 32, word width; must equal 8*WMASK_WIDTH
ADDR_WIDTH, 10, address width; RAM_DEPTH = 1<<ADDR_WIDTH
WMASK_WIDTH, 4, byte-lane write-mask width
RSP_DEPTH, 2, response FIFO entries (>=2)
CLEAR_ON_RESET, 1, 1 = zero-fill sweep after reset

Ports:
clk  in  1  clock; the same clock drives the macro
rstb  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready (fire)
req_we  in  1  1=write, 0=read
req_wmask  in  WMASK_WIDTH  byte enables for writes
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer ready
rsp_rdata  out  DATA_WIDTH  read data, in request order
init_done  out  1  high once the clear sweep completes; stays high until reset
sram_we  out  1  to macro we
sram_wmask  out  WMASK_WIDTH  to macro wmask
sram_addr  out  ADDR_WIDTH  to macro addr
sram_din  out  DATA_WIDTH  to macro din
sram_dout  in  DATA_WIDTH  from macro dout

Behaviour:
- Reset (rstb=0, asynchronous):
  - req_ready=0, rsp_valid=0, init_done=0, sram_we=0.
  - FIFO is emptied and rd_pending=0.
  - State goes to CLEAR (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0, init_done=1 after the first edge following deassertion).
- FSM states:
  - CLEAR:
    - clr_addr counts 0..RAM_DEPTH-1, one per cycle.
    - Drives sram_we=1, sram_wmask=all ones, sram_din=0, sram_addr=clr_addr.
    - req_ready=0.
    - After the write to RAM_DEPTH-1, go to RUN with init_done=1 (RAM_DEPTH cycles total).
  - RUN: normal operation. There is no exit except reset.
  - Reset asserted mid-CLEAR aborts the sweep; it restarts from address 0 after deassertion.
- Command path in RUN (combinational from the request; the macro registers it at the next posedge):
  - sram_addr=req_addr, sram_din=req_wdata, sram_wmask=req_wmask.
  - sram_we = fire & req_we. Idle cycles issue harmless reads.
- req_ready in RUN:
  - Writes: always ready (1).
  - Reads: ready iff (fifo_count + rd_pending - pop) < RSP_DEPTH, where pop = rsp_valid & rsp_ready. This is a combinational rsp_ready->req_ready path by design.
  - req_ready may depend on req_we; it must not depend on req_valid.
- Read capture:
  - A read fire sets rd_pending=1 for the next cycle. In that cycle sram_dout is pushed into the FIFO.
  - rd_pending clears unless another read fires that cycle.
  - Back-to-back reads give full throughput.
- Writes produce no response. Any macro dout following a write cycle (X) is never captured.
- Ordering: responses are returned in read-issue order. A write followed by a read to the same address returns the new data, because the macro is single-port and in order.
- FIFO:
  - rsp_rdata/rsp_valid come from the head entry.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Overflow is impossible by the credit rule; an assertion fires on push when full.
- Latency: read fire at cycle N -> rsp_valid earliest at cycle N+2 (capture at N+1, registered FIFO output).
- Partial write: only lanes with wmask[i]=1 change. wmask=0 is a legal no-op write.
- Address wrap: none; addresses beyond the depth cannot be expressed.

Test Plan:
- Reset release, CLEAR_ON_RESET=1 -> sram_we=1 for exactly 1024 cycles at addr 0..1023 with din=0; then init_done=1 and req_ready=1; read of addr 0x3FF returns 0x00000000.
- Write 0xDEADBEEF to 0x005 with wmask=4'hF, then write 0x11223344 with wmask=4'b0101, then read 0x005 -> rsp_rdata=0xDE22BE44.
- 8 back-to-back reads of addrs 0..7 after writing data=addr*0x01010101, rsp_ready=1 -> one rsp per cycle starting 2 cycles after the first fire, values in order, no req_ready drop.
- rsp_ready held 0 while issuing reads -> at most RSP_DEPTH=2 reads accepted, then req_ready=0 for reads while writes are still accepted; releasing rsp_ready drains 2 responses in order.
- Reset asserted at clear address 0x200 -> outputs return to reset values immediately; after release the sweep restarts at 0x000 and takes the full 1024 cycles.
- Alternating write/read to the same address every cycle (W 0xA5A5A5A5, R, W 0x5A5A5A5A, R) -> responses 0xA5A5A5A5, 0x5A5A5A5A; no X captured.
